// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between fetch (I) and memory stage (D).
// Define STARVE_GUARD_EN to bound consecutive D grants while fetch waits.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int TIMEOUT      = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              busy,
  output logic              err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_i_ack;
  logic              r_d_ack;
  logic              r_err;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_can;
  logic w_starved;
  logic w_gnt_d;
  logic w_gnt_i;
  logic w_tmo;
  logic w_done;

`ifdef STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;
  assign w_starved = (r_starve >= SW'(STARVE_LIMIT));
`else
  assign w_starved = 1'b0;
`endif

  // A read ack is delivered in IDLE; the requester still holds req then.
  assign w_can   = (r_state == IDLE) && !r_i_ack && !r_d_ack && !rst;
  assign w_gnt_d = w_can && d_req && !(w_starved && i_req);
  assign w_gnt_i = w_can && i_req && !w_gnt_d;
  assign w_tmo   = (r_cnt == CW'(TIMEOUT - 1));
  assign w_done  = mem_valid || w_tmo;

  assign mem_en    = w_gnt_d || w_gnt_i;
  assign mem_wr    = w_gnt_d && d_wr;
  assign mem_addr  = w_gnt_d ? d_addr :
                     w_gnt_i ? i_addr : '0;
  assign mem_wdata = (w_gnt_d && d_wr) ? d_wdata : '0;

  assign i_ack   = r_i_ack;
  assign d_ack   = r_d_ack;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign err     = r_err;
  assign busy    = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_err     <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_gnt_d) begin
            r_state <= d_wr ? D_WR : D_RD;
            r_d_ack <= d_wr;
          end else if (w_gnt_i) begin
            r_state <= I_RD;
          end
        end
        D_WR: r_state <= IDLE;
        I_RD, D_RD: begin
          if (w_done) begin
            r_state <= IDLE;
            if (!mem_valid) r_err <= 1'b1;
            if (r_state == I_RD) begin
              r_i_ack   <= 1'b1;
              r_i_rdata <= mem_valid ? mem_rdata : '0;
            end else begin
              r_d_ack   <= 1'b1;
              r_d_rdata <= mem_valid ? mem_rdata : '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef STARVE_GUARD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!i_req || w_gnt_i) begin
      r_starve <= '0;
    end else if (w_gnt_d && !w_starved) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised self-checking bench for mem_port_arbiter with a
// memory responder and a latency/data reference model.
module tb_mem_port_arbiter;
  localparam int TIMEOUT = 15;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic [15:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_valid = 1'b0;
  logic        busy;
  logic        err;

  mem_port_arbiter #(
    .ADDR_W(16), .DATA_W(16),
    .TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_wr(d_wr),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .busy(busy), .err(err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int resp_lat = 0;
  int valid_at = -1;
  logic [15:0] pend_addr = '0;
  logic [15:0] mem_arr [logic [15:0]];
  logic [15:0] exp_mem [logic [15:0]];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return init_val(a);
  endfunction

  // Memory: read data valid resp_lat cycles after mem_en (0 = never).
  always @(negedge clk) begin
    if (cyc == valid_at) begin
      mem_valid = 1'b1;
      mem_rdata = mem_read(pend_addr);
    end else begin
      mem_valid = 1'b0;
      mem_rdata = 16'hDEAD;
    end
    if (mem_en && mem_wr) begin
      mem_arr[mem_addr] = mem_wdata;
    end else if (mem_en) begin
      valid_at = (resp_lat > 0) ? cyc + resp_lat : -1;
      pend_addr = mem_addr;
    end
  end

  // Single-requester access; returns observed latency, data and bus.
  task automatic access(
    input  bit          is_d,
    input  bit          wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  int          lat,
    output int          ack_lat,
    output logic [15:0] rdata,
    output int          n_en,
    output logic [15:0] en_addr,
    output logic        en_wr,
    output logic [15:0] en_wdata,
    output bit          both
  );
    resp_lat = lat;
    if (is_d) begin
      d_req = 1'b1; d_wr = wr;
      d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    ack_lat = -1; rdata = '0; n_en = 0; both = 1'b0;
    en_addr = '0; en_wr = 1'b0; en_wdata = '0;
    for (int k = 0; k < 40 && ack_lat < 0; k++) begin
      @(negedge clk);
      if (mem_en) begin
        n_en++;
        en_addr = mem_addr;
        en_wr = mem_wr;
        en_wdata = mem_wdata;
      end
      if (i_ack && d_ack) both = 1'b1;
      if (is_d ? d_ack : i_ack) begin
        ack_lat = k;
        rdata = is_d ? d_rdata : i_rdata;
      end
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req = 1'b1; i_addr = 16'h0089;
    d_req = 1'b1; d_wr = 1'b1;
    d_addr = 16'h0123; d_wdata = 16'h4567;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_en, mem_wr, i_ack, d_ack, busy, err} !== 6'b0) begin
      errors++;
      $display("FAIL rst_ctrl: got %b want 000000",
        {mem_en, mem_wr, i_ack, d_ack, busy, err});
    end
    checks++;
    if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL rst_data: got %h want 0",
        {mem_addr, mem_wdata, i_rdata, d_rdata});
    end
    @(posedge clk); #1;
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_addr, busy} !== 18'h0) begin
      errors++;
      $display("FAIL idle_bus: got %h want 0",
        {mem_en, mem_addr, busy});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_read();
    int al, ne; logic [15:0] rd, ea, ew; logic wr; bit b;
    mem_arr[16'h0010] = 16'hA5A5;
    access(1'b0, 1'b0, 16'h0010, 16'h0, 4, al, rd, ne, ea, wr, ew, b);
    checks++;
    if (ne !== 1 || wr !== 1'b0 || ea !== 16'h0010) begin
      errors++;
      $display("FAIL i_bus: en=%0d wr=%b addr=%h want 1 0 0010",
        ne, wr, ea);
    end
    checks++;
    if (al !== 5) begin
      errors++;
      $display("FAIL i_lat: got %0d want 5", al);
    end
    checks++;
    if (rd !== 16'hA5A5 || err !== 1'b0) begin
      errors++;
      $display("FAIL i_data: got %h err=%b want a5a5 0", rd, err);
    end
  endtask

  task automatic test_write();
    int al, ne; logic [15:0] rd, ea, ew; logic wr; bit b;
    access(1'b1, 1'b1, 16'h0200, 16'h1234, 0,
      al, rd, ne, ea, wr, ew, b);
    checks++;
    if (ne !== 1 || wr !== 1'b1 || ea !== 16'h0200
        || ew !== 16'h1234) begin
      errors++;
      $display("FAIL wr_bus: en=%0d wr=%b a=%h d=%h",
        ne, wr, ea, ew);
    end
    checks++;
    if (al !== 1) begin
      errors++;
      $display("FAIL wr_lat: got %0d want 1", al);
    end
  endtask

  task automatic test_simultaneous();
    int da, ia; logic [15:0] first, dr, ir; bit ovl, seen;
    mem_arr[16'h0300] = 16'hBEEF;
    mem_arr[16'h0004] = 16'h7000;
    resp_lat = 3;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300;
    i_req = 1'b1; i_addr = 16'h0004;
    da = -1; ia = -1; first = '0; dr = '0; ir = '0;
    ovl = 1'b0; seen = 1'b0;
    for (int k = 0; k < 40 && ia < 0; k++) begin
      @(negedge clk);
      if (mem_en && !seen) begin
        seen = 1'b1;
        first = mem_addr;
      end
      if (i_ack && d_ack) ovl = 1'b1;
      if (d_ack) begin da = k; dr = d_rdata; end
      if (i_ack) begin ia = k; ir = i_rdata; end
      @(posedge clk); #1;
      if (da >= 0) d_req = 1'b0;
      if (ia >= 0) i_req = 1'b0;
    end
    @(posedge clk); #1;
    checks++;
    if (first !== 16'h0300) begin
      errors++;
      $display("FAIL sim_first: got %h want 0300", first);
    end
    checks++;
    if (da !== 4 || dr !== 16'hBEEF) begin
      errors++;
      $display("FAIL sim_d: lat=%0d data=%h want 4 beef", da, dr);
    end
    checks++;
    if (ia !== 9 || ir !== 16'h7000) begin
      errors++;
      $display("FAIL sim_i: lat=%0d data=%h want 9 7000", ia, ir);
    end
    checks++;
    if (ovl !== 1'b0) begin
      errors++;
      $display("FAIL sim_overlap: got %b want 0", ovl);
    end
  endtask

  task automatic test_timeout();
    int al, ne; logic [15:0] rd, ea, ew; logic wr; bit b;
    access(1'b1, 1'b0, 16'h0400, 16'h0, 0,
      al, rd, ne, ea, wr, ew, b);
    checks++;
    if (al !== TIMEOUT + 1 || rd !== 16'h0 || err !== 1'b1) begin
      errors++;
      $display("FAIL tmo: lat=%0d data=%h err=%b want %0d 0 1",
        al, rd, err, TIMEOUT + 1);
    end
    access(1'b1, 1'b0, 16'h0500, 16'h0, TIMEOUT,
      al, rd, ne, ea, wr, ew, b);
    checks++;
    if (al !== TIMEOUT + 1 || rd !== mem_read(16'h0500)) begin
      errors++;
      $display("FAIL tmo_edge: lat=%0d data=%h want %0d %h",
        al, rd, TIMEOUT + 1, mem_read(16'h0500));
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
    access(1'b0, 1'b0, 16'h0600, 16'h0, TIMEOUT + 1,
      al, rd, ne, ea, wr, ew, b);
    checks++;
    if (al !== TIMEOUT + 1 || rd !== 16'h0) begin
      errors++;
      $display("FAIL tmo_late: lat=%0d data=%h want %0d 0",
        al, rd, TIMEOUT + 1);
    end
  endtask

  task automatic test_rst_mid();
    int ne, na;
    resp_lat = 8;
    i_req = 1'b1; i_addr = 16'h0020;
    ne = 0; na = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_en) ne++;
    end
    @(posedge clk); #1;
    rst = 1'b1; i_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ne !== 1 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: en=%0d busy=%b err=%b want 1 0 0",
        ne, busy, err);
    end
    ne = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_en) ne++;
      if (i_ack) na++;
    end
    checks++;
    if (na !== 0 || ne !== 0 || i_rdata !== 16'h0) begin
      errors++;
      $display("FAIL rst_late: ack=%0d en=%0d rd=%h want 0 0 0",
        na, ne, i_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int al, ne, lat, xl; logic [15:0] rd, ea, ew, a, wd, xd;
    logic wr; bit b, isd, w, tmo, xerr;
    xerr = 1'b0;
    for (int n = 0; n < 40; n++) begin
      isd = 1'($urandom_range(0, 1));
      w = isd && ($urandom_range(0, 2) == 0);
      a = 16'h1000 + 16'($urandom_range(0, 7) * 2);
      wd = 16'($urandom);
      lat = $urandom_range(0, TIMEOUT + 3);
      access(isd, w, a, wd, lat, al, rd, ne, ea, wr, ew, b);
      tmo = !w && (lat == 0 || lat > TIMEOUT);
      if (w) begin
        xl = 1; xd = rd;
        exp_mem[a] = wd;
      end else begin
        xl = tmo ? TIMEOUT + 1 : lat + 1;
        xd = tmo ? 16'h0 :
             exp_mem.exists(a) ? exp_mem[a] : init_val(a);
      end
      xerr = xerr | tmo;
      checks++;
      if (al !== xl || rd !== xd) begin
        errors++;
        $display("FAIL rnd%0d ack: lat=%0d d=%h want %0d %h",
          n, al, rd, xl, xd);
      end
      checks++;
      if (ne !== 1 || ea !== a || wr !== w
          || (w && ew !== wd) || b) begin
        errors++;
        $display("FAIL rnd%0d bus: en=%0d a=%h wr=%b d=%h ovl=%b",
          n, ne, ea, wr, ew, b);
      end
      checks++;
      if (err !== xerr) begin
        errors++;
        $display("FAIL rnd%0d err: got %b want %b", n, err, xerr);
      end
    end
  endtask

  task automatic test_starve();
    int dg, db, xdb; bit ig, idone, ovl; logic [15:0] ird;
`ifdef STARVE_GUARD_EN
    xdb = STARVE_LIMIT;
`else
    xdb = 10;
`endif
    dg = 0; db = -1; ig = 1'b0; idone = 1'b0;
    ovl = 1'b0; ird = '0;
    resp_lat = 2;
    d_req = 1'b1; d_wr = 1'b1;
    d_addr = 16'h0700; d_wdata = 16'h1000;
    i_req = 1'b1; i_addr = 16'h0040;
    for (int k = 0; k < 80 && !idone; k++) begin
      @(negedge clk);
      if (mem_en && mem_wr) dg++;
      if (mem_en && !mem_wr && !ig) begin
        ig = 1'b1;
        db = dg;
      end
      if (i_ack && d_ack) ovl = 1'b1;
      if (i_ack) begin idone = 1'b1; ird = i_rdata; end
      @(posedge clk); #1;
      if (d_ack) begin
        d_addr = d_addr + 16'd2;
        d_wdata = d_wdata + 16'd1;
        if (dg >= 10) d_req = 1'b0;
      end
      if (ig) d_req = 1'b0;
      if (idone) i_req = 1'b0;
    end
    d_wr = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (!idone || db !== xdb) begin
      errors++;
      $display("FAIL starve: done=%b d_grants=%0d want 1 %0d",
        idone, db, xdb);
    end
    checks++;
    if (ird !== init_val(16'h0040) || ovl) begin
      errors++;
      $display("FAIL starve_i: d=%h ovl=%b want %h 0",
        ird, ovl, init_val(16'h0040));
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_write();
    test_simultaneous();
    test_timeout();
    test_rst_mid();
    test_random();
    test_starve();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
